// File: rtl/regfile_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_ctrl_if
//  Brief    : Bundle of writeback requester, issue, decode and register-file
//             write-port signals around the writeback controller.
//             master = pipeline side (requesters, issue, decode)
//             slave  = the writeback controller itself
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_ctrl_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int XLEN = 32
);
    // ALU writeback requester
    logic            wb0_valid;
    logic            wb0_ready;
    logic [AW-1:0]   wb0_rd;
    logic [XLEN-1:0] wb0_data;

    // LSU / long-latency writeback requester
    logic            wb1_valid;
    logic            wb1_ready;
    logic [AW-1:0]   wb1_rd;
    logic [XLEN-1:0] wb1_data;

    // Long-latency issue marks its destination pending
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;

    // Register indices of the instruction sitting in decode
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   dec_rd;

    // Status back to decode
    logic            hazard;
    logic            init_busy;

    // Register-file write port
    logic            RegWrite;
    logic [AW-1:0]   wr_rd;
    logic [XLEN-1:0] wr_data;

    // Pending-write scoreboard
    logic [NREG-1:0] busy_vec;

    modport master (
        output wb0_valid, wb0_rd, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb1_ready,
        output iss_valid, iss_rd,
        output rs1, rs2, dec_rd,
        input  hazard, init_busy,
        input  RegWrite, wr_rd, wr_data,
        input  busy_vec
    );

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb1_ready,
        input  iss_valid, iss_rd,
        input  rs1, rs2, dec_rd,
        output hazard, init_busy,
        output RegWrite, wr_rd, wr_data,
        output busy_vec
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_ctrl
//  Brief    : Owner of the single register-file write port. Zero-fills every
//             register after reset, then round-robin arbitrates between the
//             ALU (wb0) and LSU (wb1) writeback requesters. Tracks pending
//             long-latency destinations and raises a decode hazard on
//             RAW/WAW conflicts against them.
//             Note: rst_n is an asynchronous ACTIVE-HIGH reset despite its name.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wb_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);
    localparam logic [AW-1:0] c_x0       = '0;
    localparam logic          c_src_wb0  = 1'b0;
    localparam logic          c_src_wb1  = 1'b1;

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_next;
    logic            r_rr;          // 0: wb0 preferred, 1: wb1 preferred
    logic            w_rr_next;

    // Grants and status
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_init_busy;

    // Write-port registers and their next values
    logic            r_regwrite;
    logic [AW-1:0]   r_wr_rd;
    logic [XLEN-1:0] r_wr_data;
    logic            r_src;         // source of the write currently presented
    logic            w_wr_en_next;
    logic [AW-1:0]   w_wr_rd_next;
    logic [XLEN-1:0] w_wr_data_next;
    logic            w_src_next;

    // Scoreboard
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    // ------------------------------------------------------------------------
    // FSM state, fill counter and round-robin pointer registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rr    <= w_rr_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state, fill counter advance and writeback arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rr_next    = r_rr;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_init_busy  = 1'b0;

        case (r_state)
            ST_INIT: begin
                // Requesters are held off while the file is being cleared;
                // the last fill write moves us into RUN on the same edge.
                w_init_busy = 1'b1;
                w_cnt_next  = r_cnt + AW'(1);
                if (r_cnt == c_last_idx) begin
                    w_state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                // RUN is terminal; only reset leaves it.
                if (bus.wb0_valid && bus.wb1_valid) begin
                    w_gnt0 = ~r_rr;
                    w_gnt1 =  r_rr;
                end else begin
                    w_gnt0 = bus.wb0_valid;
                    w_gnt1 = bus.wb1_valid;
                end
                // After any grant, prefer the requester that was not served.
                if (w_gnt0) begin
                    w_rr_next = 1'b1;
                end else if (w_gnt1) begin
                    w_rr_next = 1'b0;
                end
            end

            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next values for the register-file write port
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_en_next   = 1'b0;
        w_wr_rd_next   = r_wr_rd;
        w_wr_data_next = r_wr_data;
        w_src_next     = r_src;

        if (r_state == ST_INIT) begin
            w_wr_en_next   = 1'b1;
            w_wr_rd_next   = r_cnt;
            w_wr_data_next = '0;
            w_src_next     = c_src_wb0;
        end else if (w_gnt0) begin
            // x0 writes are accepted but never reach the file.
            w_wr_en_next   = (bus.wb0_rd != c_x0);
            w_wr_rd_next   = bus.wb0_rd;
            w_wr_data_next = bus.wb0_data;
            w_src_next     = c_src_wb0;
        end else if (w_gnt1) begin
            w_wr_en_next   = (bus.wb1_rd != c_x0);
            w_wr_rd_next   = bus.wb1_rd;
            w_wr_data_next = bus.wb1_data;
            w_src_next     = c_src_wb1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port (one cycle after acceptance)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_regwrite <= 1'b0;
            r_wr_rd    <= '0;
            r_wr_data  <= '0;
            r_src      <= c_src_wb0;
        end else begin
            r_regwrite <= w_wr_en_next;
            r_wr_rd    <= w_wr_rd_next;
            r_wr_data  <= w_wr_data_next;
            r_src      <= w_src_next;
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard next value: a wb1 result clears its bit on the edge the file
    // stores it; a same-edge issue to that index re-sets it (set wins).
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 0; i < NREG; i++) begin
            if (r_regwrite && (r_src == c_src_wb1) && (r_wr_rd == AW'(i))) begin
                w_busy_next[i] = 1'b0;
            end
            if ((r_state == ST_RUN) && bus.iss_valid && (bus.iss_rd == AW'(i))) begin
                w_busy_next[i] = 1'b1;
            end
        end
        // x0 never holds a pending result.
        w_busy_next[0] = 1'b0;
    end

    // ------------------------------------------------------------------------
    // Scoreboard register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The dec_rd term keeps a younger write from overtaking an
    // outstanding long-latency result to the same register.
    // ------------------------------------------------------------------------
    assign bus.wb0_ready = w_gnt0;
    assign bus.wb1_ready = w_gnt1;
    assign bus.init_busy = w_init_busy;
    assign bus.hazard    = w_init_busy
                         | r_busy[bus.rs1]
                         | r_busy[bus.rs2]
                         | r_busy[bus.dec_rd];
    assign bus.RegWrite  = r_regwrite;
    assign bus.wr_rd     = r_wr_rd;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy_vec  = r_busy;

endmodule
`default_nettype wire
